pwm_duty_ctrl: RTL

Button-driven duty-cycle controller that sits between the two raw user buttons (increase/decrease) and the PWM generator. It synchronises and debounces both buttons and arbitrates between them, so that simultaneous presses cancel. It issues single-cycle step commands with hold-to-auto-repeat and maintains the saturating duty register that configures the PWM compare value. One shared FSM serves both requesters, so at most one step is issued per cycle.

---
 rtl/pwm_duty_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pwm_duty_ctrl.sv
// Button-driven duty-cycle controller: synchronises and debounces the inc/dec buttons,
// cancels simultaneous presses, and steps a saturating duty register with hold-to-auto-repeat.
module pwm_duty_ctrl #(
    parameter int DUTY_W        = 4,
    parameter int DUTY_RESET    = 8,
    parameter int DEB_CYCLES    = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_btn,
    input  logic              dec_btn,
    output logic [DUTY_W-1:0] duty,
    output logic              step_up,
    output logic              step_dn,
    output logic              busy
);
    localparam int DH_MAX  = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX = (DH_MAX > REPEAT_CYCLES) ? DH_MAX : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
    localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(DUTY_RESET);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, FIRE, HOLD} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              dir_reg, dir_next;      // 1 = up, 0 = down
    logic              rep_reg, rep_next;
    logic [DUTY_W-1:0] duty_reg, duty_next;

    // Index 1 = increase button, index 0 = decrease button.
    logic [1:0] btn_raw;
    logic [1:0] btn_s;
    assign btn_raw = {inc_btn, dec_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] sync_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[0], btn_raw[gi]};
                end
            end
            assign btn_s[gi] = sync_reg[1];
        end
    endgenerate

    // Both pressed decodes to neither request, so the buttons cancel without priority.
    logic req_up, req_dn, req_match;
    logic [CNT_W-1:0] hold_last;
    assign req_up    = btn_s[1] & ~btn_s[0];
    assign req_dn    = ~btn_s[1] & btn_s[0];
    assign req_match = dir_reg ? req_up : req_dn;
    assign hold_last = rep_reg ? REP_LAST : HOLD_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            rep_reg   <= 1'b0;
            duty_reg  <= DUTY_INIT;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            rep_reg   <= rep_next;
            duty_reg  <= duty_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        rep_next   = rep_reg;
        case (state_reg)
            IDLE: begin
                if (req_up || req_dn) begin
                    dir_next   = req_up;
                    cnt_next   = '0;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!req_match) begin
                    state_next = IDLE;
                end else if (cnt_reg == DEB_LAST) begin
                    rep_next   = 1'b0;
                    state_next = FIRE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            // FIRE lasts exactly one cycle and ignores the request.
            FIRE: begin
                cnt_next   = '0;
                state_next = HOLD;
            end
            HOLD: begin
                if (!req_match) begin
                    state_next = IDLE;
                end else if (cnt_reg == hold_last) begin
                    rep_next   = 1'b1;
                    state_next = FIRE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulses come only from registered state, so they have no path from the buttons.
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        busy    = (state_reg != IDLE);
        if (state_reg == FIRE) begin
            step_up = dir_reg && (duty_reg != DUTY_MAX);
            step_dn = !dir_reg && (duty_reg != '0);
        end
    end

    always_comb begin
        duty_next = duty_reg;
        if (step_up) begin
            duty_next = duty_reg + DUTY_W'(1);
        end else if (step_dn) begin
            duty_next = duty_reg - DUTY_W'(1);
        end
    end

    assign duty = duty_reg;

endmodule
